// File: rtl/io_pinmux_matrix_pkg.sv
// Shared constants, bus FSM state type and helper functions for the io_pinmux_matrix pad multiplexer.
package io_pinmux_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 32;
  localparam int REG_STRB_W = 4;
  localparam int GUARD_W    = 4;

  localparam logic [REG_ADDR_W-1:0] ADDR_SEL       = 4'h0;
  localparam logic [REG_ADDR_W-1:0] ADDR_INV       = 4'h1;
  localparam logic [REG_ADDR_W-1:0] ADDR_PAD_IN    = 4'h2;
  localparam logic [REG_ADDR_W-1:0] ADDR_EDGE_RISE = 4'h3;
  localparam logic [REG_ADDR_W-1:0] ADDR_EDGE_FALL = 4'h4;
  localparam logic [REG_ADDR_W-1:0] ADDR_GUARD     = 4'h5;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  function automatic bit params_legal(input int pin_num, input int func_num, input int func_w,
                                      input int sync_stages, input int guard_cyc);
    return (pin_num >= 1) && (pin_num <= 16) && (func_num >= 2) && (func_num <= 4) &&
           ((func_num & (func_num - 1)) == 0) && (pin_num * func_w <= 32) &&
           (sync_stages >= 2) && (guard_cyc >= 1) && (guard_cyc <= 15);
  endfunction

  function automatic logic [REG_DATA_W-1:0] strb_mask(input logic [REG_STRB_W-1:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/io_pinmux_matrix_if.sv
// Register bus between the SoC and the pad multiplexer: request with byte strobes, registered reply.
interface io_pinmux_matrix_if;
  import io_pinmux_pkg::*;

  logic                  reg_valid_i;
  logic [REG_ADDR_W-1:0] reg_addr_i;
  logic [REG_DATA_W-1:0] reg_wdata_i;
  logic [REG_STRB_W-1:0] reg_wstrb_i;
  logic [REG_DATA_W-1:0] reg_rdata_o;
  logic                  reg_ready_o;

  modport master (
    output reg_valid_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    input  reg_rdata_o, reg_ready_o
  );

  modport slave (
    input  reg_valid_i, reg_addr_i, reg_wdata_i, reg_wstrb_i,
    output reg_rdata_o, reg_ready_o
  );
endinterface

// File: rtl/io_pinmux_matrix_pad.sv
// One pad slice: input synchroniser with inversion, edge detection, function-change guard and function mux.
module io_pinmux_pad
  import io_pinmux_pkg::*;
#(
  parameter int FUNC_NUM    = 4,
  parameter int FUNC_W      = 2,
  parameter int SYNC_STAGES = 2,
  parameter int GUARD_CYC   = 2
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [FUNC_W-1:0]   sel_i,
  input  logic                sel_load_i,
  input  logic                inv_i,
  input  logic                pad_in_i,
  input  logic [FUNC_NUM-1:0] func_out_i,
  input  logic [FUNC_NUM-1:0] func_oe_i,
  output logic [FUNC_NUM-1:0] func_in_o,
  output logic                pad_out_o,
  output logic                pad_oe_o,
  output logic                pad_s_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                guard_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_s;
  logic                   s_dly_q, s_dly_d;
  logic [GUARD_W-1:0]     guard_q, guard_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], pad_in_i};
    s_s     = sync_q[SYNC_STAGES-1] ^ inv_i;
    s_dly_d = s_s;
  end

  // A field change (re)starts the guard, otherwise it drains to zero.
  always_comb begin
    guard_d = guard_q;
    if (sel_load_i) begin
      guard_d = GUARD_W'(GUARD_CYC);
    end else if (guard_q != {GUARD_W{1'b0}}) begin
      guard_d = guard_q - {{(GUARD_W-1){1'b0}}, 1'b1};
    end else begin
      guard_d = guard_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= {SYNC_STAGES{1'b0}};
      s_dly_q <= 1'b0;
      guard_q <= GUARD_W'(GUARD_CYC);
    end else begin
      sync_q  <= sync_d;
      s_dly_q <= s_dly_d;
      guard_q <= guard_d;
    end
  end

  always_comb begin
    func_in_o = {FUNC_NUM{1'b0}};
    for (int f = 0; f < FUNC_NUM; f++) begin
      if (sel_i == FUNC_W'(f)) begin
        func_in_o[f] = s_s;
      end else begin
        func_in_o[f] = 1'b0;
      end
    end
  end

  assign pad_out_o = func_out_i[sel_i];
  assign pad_oe_o  = func_oe_i[sel_i] & (guard_q == {GUARD_W{1'b0}});
  assign pad_s_o   = s_s;
  assign rise_o    = s_s & ~s_dly_q;
  assign fall_o    = ~s_s & s_dly_q;
  assign guard_o   = (guard_q != {GUARD_W{1'b0}});

endmodule

// File: rtl/io_pinmux_matrix.sv
// Runtime-programmable pad multiplexer: register file, bus handshake FSM and one io_pinmux_pad per pad.
module io_pinmux_matrix
  import io_pinmux_pkg::*;
#(
  parameter int                          PIN_NUM     = 8,
  parameter int                          FUNC_NUM    = 4,
  parameter int                          FUNC_W      = $clog2(FUNC_NUM),
  parameter int                          SYNC_STAGES = 2,
  parameter int                          GUARD_CYC   = 2,
  parameter logic [PIN_NUM*FUNC_W-1:0]   DEFAULT_SEL = '0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  io_pinmux_matrix_if.slave            bus,
  input  logic [PIN_NUM*FUNC_NUM-1:0]  func_out_i,
  input  logic [PIN_NUM*FUNC_NUM-1:0]  func_oe_i,
  output logic [PIN_NUM*FUNC_NUM-1:0]  func_in_o,
  input  logic [PIN_NUM-1:0]           pad_in_i,
  output logic [PIN_NUM-1:0]           pad_out_o,
  output logic [PIN_NUM-1:0]           pad_oe_o
);

  localparam int SEL_W = PIN_NUM * FUNC_W;

  if (!params_legal(PIN_NUM, FUNC_NUM, FUNC_W, SYNC_STAGES, GUARD_CYC)) begin : g_param_check
    $error("io_pinmux_matrix: illegal parameter combination");
  end

  bus_state_e            state_q, state_d;
  logic [REG_DATA_W-1:0] rdata_q, rdata_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [PIN_NUM-1:0]    inv_q, inv_d;
  logic [PIN_NUM-1:0]    rise_q, rise_d;
  logic [PIN_NUM-1:0]    fall_q, fall_d;

  logic                  fire_s, wr_s, rd_s;
  logic [REG_DATA_W-1:0] wmask_s, wbits_s, rd_val_s;
  logic [PIN_NUM-1:0]    sel_load_s, pad_s_s, rise_s, fall_s, guard_s;

  // Bus FSM: a request seen in IDLE completes with a one-cycle ACK.
  always_comb begin
    state_d = state_q;
    rdata_d = {REG_DATA_W{1'b0}};
    fire_s  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (bus.reg_valid_i) begin
          fire_s  = 1'b1;
          state_d = BUS_ACK;
          rdata_d = (bus.reg_wstrb_i == 4'b0000) ? rd_val_s : {REG_DATA_W{1'b0}};
        end else begin
          state_d = BUS_IDLE;
        end
      end
      BUS_ACK:  state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= BUS_IDLE;
      rdata_q <= {REG_DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.reg_ready_o = (state_q == BUS_ACK);
  assign bus.reg_rdata_o = rdata_q;

  always_comb begin
    rd_val_s = {REG_DATA_W{1'b0}};
    case (bus.reg_addr_i)
      ADDR_SEL:       rd_val_s = 32'(sel_q);
      ADDR_INV:       rd_val_s = 32'(inv_q);
      ADDR_PAD_IN:    rd_val_s = 32'(pad_s_s);
      ADDR_EDGE_RISE: rd_val_s = 32'(rise_q);
      ADDR_EDGE_FALL: rd_val_s = 32'(fall_q);
      ADDR_GUARD:     rd_val_s = 32'(guard_s);
      default:        rd_val_s = {REG_DATA_W{1'b0}};
    endcase
  end

  assign wr_s    = fire_s && (bus.reg_wstrb_i != 4'b0000);
  assign rd_s    = fire_s && (bus.reg_wstrb_i == 4'b0000);
  assign wmask_s = strb_mask(bus.reg_wstrb_i);
  assign wbits_s = bus.reg_wdata_i & wmask_s;

  // Register writes; an edge seen in the same cycle as its W1C clear survives.
  always_comb begin
    sel_d  = sel_q;
    inv_d  = inv_q;
    rise_d = rise_q | rise_s;
    fall_d = fall_q | fall_s;
    if (wr_s) begin
      case (bus.reg_addr_i)
        ADDR_SEL:       sel_d  = (sel_q & ~wmask_s[SEL_W-1:0]) | wbits_s[SEL_W-1:0];
        ADDR_INV:       inv_d  = (inv_q & ~wmask_s[PIN_NUM-1:0]) | wbits_s[PIN_NUM-1:0];
        ADDR_EDGE_RISE: rise_d = (rise_q & ~wbits_s[PIN_NUM-1:0]) | rise_s;
        ADDR_EDGE_FALL: fall_d = (fall_q & ~wbits_s[PIN_NUM-1:0]) | fall_s;
        default:        sel_d  = sel_q;
      endcase
    end else begin
      sel_d = sel_q;
    end
  end

  always_comb begin
    sel_load_s = {PIN_NUM{1'b0}};
    for (int p = 0; p < PIN_NUM; p++) begin
      if (sel_d[p*FUNC_W +: FUNC_W] != sel_q[p*FUNC_W +: FUNC_W]) begin
        sel_load_s[p] = 1'b1;
      end else begin
        sel_load_s[p] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sel_q  <= DEFAULT_SEL;
      inv_q  <= {PIN_NUM{1'b0}};
      rise_q <= {PIN_NUM{1'b0}};
      fall_q <= {PIN_NUM{1'b0}};
    end else begin
      sel_q  <= sel_d;
      inv_q  <= inv_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  for (genvar p = 0; p < PIN_NUM; p++) begin : g_pad
    io_pinmux_pad #(
      .FUNC_NUM    (FUNC_NUM),
      .FUNC_W      (FUNC_W),
      .SYNC_STAGES (SYNC_STAGES),
      .GUARD_CYC   (GUARD_CYC)
    ) u_pad (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .sel_i      (sel_q[p*FUNC_W +: FUNC_W]),
      .sel_load_i (sel_load_s[p]),
      .inv_i      (inv_q[p]),
      .pad_in_i   (pad_in_i[p]),
      .func_out_i (func_out_i[p*FUNC_NUM +: FUNC_NUM]),
      .func_oe_i  (func_oe_i[p*FUNC_NUM +: FUNC_NUM]),
      .func_in_o  (func_in_o[p*FUNC_NUM +: FUNC_NUM]),
      .pad_out_o  (pad_out_o[p]),
      .pad_oe_o   (pad_oe_o[p]),
      .pad_s_o    (pad_s_s[p]),
      .rise_o     (rise_s[p]),
      .fall_o     (fall_s[p]),
      .guard_o    (guard_s[p])
    );
  end

  logic unused_rd_s;
  assign unused_rd_s = rd_s;

endmodule

// File: doc/io_pinmux_matrix.md
Name: io_pinmux_matrix

Overview:
Runtime-programmable pad multiplexer that replaces fixed top-level pin assignment in the retroSoC tiny wrapper. Each of PIN_NUM bidirectional pads selects one of FUNC_NUM peripheral functions (GPIO, UART, QSPI, PSRAM, SPFS, ...) through memory-mapped registers. Pad inputs are synchronised and edge-detected. A guard interval tri-states a pad whenever its function changes, so two drivers never overlap. The block sits between the SoC peripheral signals and the top-level ui_in/uo_out/uio_* pins and is attached to the SoC register bus.

Parameters:
PIN_NUM, 8, number of pads; 1..16
FUNC_NUM, 4, functions per pad; power of two, 2..4
FUNC_W, $clog2(FUNC_NUM), select field width per pad (derived)
SYNC_STAGES, 2, input synchroniser depth; >=2
GUARD_CYC, 2, cycles pad_oe_o is forced low after a function change; 1..15
DEFAULT_SEL, 0, PIN_NUM*FUNC_W reset value of the SEL register

Ports:
clk_i  input  1  system clock
rst_n_i  input  1  reset; asynchronous, active-low
reg_valid_i  input  1  bus request
reg_addr_i  input  4  word address
reg_wdata_i  input  32  write data
reg_wstrb_i  input  4  byte strobes; all zero = read
reg_rdata_o  output  32  read data, valid while reg_ready_o=1
reg_ready_o  output  1  one-cycle completion pulse
func_out_i  input  PIN_NUM*FUNC_NUM  per-function output value; index p*FUNC_NUM+f
func_oe_i  input  PIN_NUM*FUNC_NUM  per-function output enable, active-high
func_in_o  output  PIN_NUM*FUNC_NUM  per-function input value
pad_in_i  input  PIN_NUM  raw pad input
pad_out_o  output  PIN_NUM  pad output value
pad_oe_o  output  PIN_NUM  pad output enable, active-high

Behaviour:
- Clock and reset: one clock, clk_i. rst_n_i is asynchronous and active-low. Every flop clears asynchronously.
- Reset values:
  - reg_ready_o=0, reg_rdata_o=0.
  - SEL=DEFAULT_SEL; INV, EDGE_RISE and EDGE_FALL=0.
  - Synchroniser flops=0.
  - Guard counters=GUARD_CYC, so pad_oe_o=0 for GUARD_CYC cycles after reset release.
  - func_in_o=0.
- Register map (word address):
  - 0x0 SEL: FUNC_W bits per pad, pad p at [p*FUNC_W +: FUNC_W]. RW.
  - 0x1 INV: per-pad input inversion. RW.
  - 0x2 PAD_IN: synchronised, post-inversion pad value. RO.
  - 0x3 EDGE_RISE: sticky rising-edge flags. Write-1-to-clear.
  - 0x4 EDGE_FALL: sticky falling-edge flags. Write-1-to-clear.
  - 0x5 GUARD: 1 for each pad currently in its guard interval. RO.
  - Bits above PIN_NUM (or above PIN_NUM*FUNC_W for SEL) read 0 and ignore writes.
- Bus handshake:
  - reg_ready_o pulses for exactly one cycle, in the cycle after reg_valid_i is sampled with reg_ready_o=0. Read data is registered and valid in that same cycle.
  - The master holds the request until it sees ready; back-to-back requests therefore complete every 2 cycles.
  - Writes honour byte strobes and take effect at the ready edge.
  - Unmapped address: read returns 0, write is dropped, ready still pulses.
- Output path (combinational):
  - pad_out_o[p] = func_out_i[p*FUNC_NUM+SEL[p]].
  - pad_oe_o[p] = func_oe_i[p*FUNC_NUM+SEL[p]] & (guard_cnt[p]==0).
- Guard interval:
  - A SEL write that changes pad p's field loads guard_cnt[p]=GUARD_CYC. The counter decrements each cycle to 0.
  - Writing the same value does not load the counter.
  - A change during an active guard reloads the counter to GUARD_CYC.
- Input path:
  - pad_in_i[p] passes through SYNC_STAGES flops, then XOR INV[p], giving s[p].
  - func_in_o[p*FUNC_NUM+f] = s[p] when SEL[p]==f, else 0.
  - Latency from pad edge to func_in_o is SYNC_STAGES cycles, plus up to one cycle of sampling uncertainty.
- Edge detection:
  - A registered copy of s[p] gives s_d[p].
  - s & ~s_d sets EDGE_RISE[p]; ~s & s_d sets EDGE_FALL[p].
  - If a W1C clear and a set hit the same cycle, set wins.
  - An INV toggle causes an edge event on the next cycle; this is intentional and documented for software.
- Reset mid-transaction: any pending bus request is dropped. The master reissues it after reset.

Decomposition:
- Package io_pinmux_pkg:
  - Register offset localparams: SEL=0x0, INV=0x1, PAD_IN=0x2, EDGE_RISE=0x3, EDGE_FALL=0x4, GUARD=0x5.
  - GUARD_W=4.
  - A parameter-legality check: PIN_NUM*FUNC_W<=32.
- Sub-module io_pinmux_pad, one instance per pad. It contains the synchroniser, inversion, edge detector, guard counter and function mux.
- The top level holds the register file and bus FSM.

Test Plan:
- Reset release with DEFAULT_SEL=0 and func_oe_i all 1 -> pad_oe_o=0x00 for 2 cycles, then 0xFF; reg_ready_o=0 throughout reset.
- Write SEL=0x0004 (pad1 -> function 1) with func_oe_i[5]=1 -> GUARD reads 0x02, pad_oe_o[1]=0 for 2 cycles, then pad_out_o[1] follows func_out_i[5].
- Drive pad_in_i[3] 0->1 -> func_in_o[12] rises exactly 2 cycles later, EDGE_RISE reads 0x08. Write 0x08 to EDGE_RISE -> reads 0x00.
- Write INV=0x01 with pad_in_i[0]=0 -> PAD_IN reads 0x01 and EDGE_RISE[0] sets. W1C issued in the same cycle as a new rising edge -> flag stays 1.
- Read address 0xF -> rdata=0 with a one-cycle ready pulse. Write SEL with the identical value -> GUARD stays 0x00.
- Assert rst_n_i mid-guard and mid-read -> all registers return to reset values immediately and reg_ready_o=0.
